// File: rtl/mandelbrot_render_engine.sv
// Mandelbrot escape-iteration renderer: walks one frame in raster order and hands out one
// {iter, y, x} word per pixel over a ready/send_data handshake.
module mandelbrot_render_engine #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_PIXELS = 480,
  parameter int unsigned MAX_ITER = 255,
  parameter logic [31:0] X_MIN    = 32'hD8000000,
  parameter logic [31:0] Y_MAX    = 32'h14000000,
  parameter logic [31:0] STEP     = 32'h00166666
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start_render,
  input  logic        send_data,
  output logic [31:0] data,
  output logic        ready,
  output logic        frame_ready
);

  typedef enum logic [2:0] {StIdle, StSetup, StCalc, StHold, StDone} state_e;

  // 4.0 in the Q8.56 format of a full 64-bit product of two Q4.28 values.
  localparam logic signed [64:0] FourQ56 = 65'sh0_0400_0000_0000_0000;

  state_e             state_q;
  logic        [11:0] x_q, y_q;
  logic        [7:0]  n_q;
  logic signed [31:0] c_re_q, c_im_q, zr_q, zi_q;
  logic        [31:0] data_q;
  logic               ready_q, frame_ready_q;

  logic signed [63:0] zr_w, zi_w, sq_re, sq_im, prod, diff;
  logic signed [64:0] mag;
  logic signed [31:0] zr_nx, zi_nx;
  logic               escape;

  always_comb begin
    zr_w   = zr_q;
    zi_w   = zi_q;
    sq_re  = zr_w * zr_w;
    sq_im  = zi_w * zi_w;
    prod   = zr_w * zi_w;
    mag    = 65'(sq_re) + 65'(sq_im);
    escape = mag > FourQ56;
    diff   = sq_re - sq_im;
    zr_nx  = 32'(diff >>> 28) + c_re_q;
    // 2*zr*zi truncated to Q4.28 is the product shifted by one bit less.
    zi_nx  = 32'(prod >>> 27) + c_im_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      n_q           <= '0;
      c_re_q        <= '0;
      c_im_q        <= '0;
      zr_q          <= '0;
      zi_q          <= '0;
      data_q        <= '0;
      ready_q       <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_render) begin
            x_q           <= '0;
            y_q           <= '0;
            c_re_q        <= X_MIN;
            c_im_q        <= Y_MAX;
            frame_ready_q <= 1'b0;
            state_q       <= StSetup;
          end
        end
        StSetup: begin
          zr_q    <= '0;
          zi_q    <= '0;
          n_q     <= '0;
          state_q <= StCalc;
        end
        StCalc: begin
          if (escape || n_q == 8'(MAX_ITER)) begin
            data_q  <= {n_q, y_q, x_q};
            ready_q <= 1'b1;
            state_q <= StHold;
          end else begin
            zr_q <= zr_nx;
            zi_q <= zi_nx;
            n_q  <= n_q + 8'd1;
          end
        end
        StHold: begin
          if (send_data) begin
            ready_q <= 1'b0;
            if (x_q != 12'(H_PIXELS - 1)) begin
              x_q     <= x_q + 12'd1;
              c_re_q  <= c_re_q + STEP;
              state_q <= StSetup;
            end else if (y_q != 12'(V_PIXELS - 1)) begin
              x_q     <= '0;
              y_q     <= y_q + 12'd1;
              c_re_q  <= X_MIN;
              c_im_q  <= c_im_q - STEP;
              state_q <= StSetup;
            end else begin
              frame_ready_q <= 1'b1;
              state_q       <= StDone;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data        = data_q;
  assign ready       = ready_q;
  assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_mandelbrot_render_engine.sv
// Directed bench: three small-frame renderer instances checked against hand-computed words.
module tb_mandelbrot_render_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start;
  logic [2:0]  send;
  logic [2:0]  rdy;
  logic [2:0]  frdy;
  logic [31:0] dat [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // 0: 4x1 frame, c = -2, -1, 0, 1
  mandelbrot_render_engine #(
    .H_PIXELS(4), .V_PIXELS(1), .MAX_ITER(255),
    .X_MIN(32'hE0000000), .Y_MAX(32'h00000000), .STEP(32'h10000000)
  ) dut_a (
    .CLK(clk), .reset(reset), .start_render(start[0]), .send_data(send[0]),
    .data(dat[0]), .ready(rdy[0]), .frame_ready(frdy[0])
  );

  // 1: single pixel, c = 2
  mandelbrot_render_engine #(
    .H_PIXELS(1), .V_PIXELS(1), .MAX_ITER(255),
    .X_MIN(32'h20000000), .Y_MAX(32'h00000000), .STEP(32'h10000000)
  ) dut_b (
    .CLK(clk), .reset(reset), .start_render(start[1]), .send_data(send[1]),
    .data(dat[1]), .ready(rdy[1]), .frame_ready(frdy[1])
  );

  // 2: 1x2 frame, c = 2i then 0
  mandelbrot_render_engine #(
    .H_PIXELS(1), .V_PIXELS(2), .MAX_ITER(255),
    .X_MIN(32'h00000000), .Y_MAX(32'h20000000), .STEP(32'h20000000)
  ) dut_c (
    .CLK(clk), .reset(reset), .start_render(start[2]), .send_data(send[2]),
    .data(dat[2]), .ready(rdy[2]), .frame_ready(frdy[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick(1);
    start[d] = 1'b0;
  endtask

  task automatic pulse_send(input int d);
    send[d] = 1'b1;
    tick(1);
    send[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d, input string tag);
    int cnt = 0;
    while (rdy[d] !== 1'b1 && cnt < 600) begin
      tick(1);
      cnt++;
    end
    check({tag, "_ready"}, 32'(rdy[d]), 32'd1);
  endtask

  logic [31:0] held;

  initial begin
    reset = 1'b1;
    start = '0;
    send  = '0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_data", dat[0], 32'h0);
    check("rst_ready", 32'(rdy[0]), 32'd0);
    check("rst_frame_ready", 32'(frdy[0]), 32'd0);

    // Single pixel c=2 escapes after 2 updates.
    pulse_start(1);
    wait_ready(1, "b_px0");
    check("b_c2_word", dat[1], {8'd2, 12'd0, 12'd0});
    pulse_send(1);
    check("b_frame_ready", 32'(frdy[1]), 32'd1);

    // Column frame: c=2i escapes at 2, then y advances to c=0.
    pulse_start(2);
    wait_ready(2, "c_px0");
    check("c_2i_word", dat[2], {8'd2, 12'd0, 12'd0});
    pulse_send(2);
    check("c_mid_frame_ready", 32'(frdy[2]), 32'd0);
    wait_ready(2, "c_px1");
    check("c_y1_word", dat[2], {8'd255, 12'd1, 12'd0});
    pulse_send(2);
    check("c_frame_ready", 32'(frdy[2]), 32'd1);

    // send_data while idle must not move the pixel pointer.
    pulse_send(0);
    pulse_start(0);
    tick(3);
    pulse_send(0);
    wait_ready(0, "a_px0");
    check("a_x0_word", dat[0], {8'd255, 12'd0, 12'd0});

    held = dat[0];
    tick(100);
    check("a_hold_ready", 32'(rdy[0]), 32'd1);
    check("a_hold_data", dat[0], held);

    pulse_send(0);
    check("a_consume_ready", 32'(rdy[0]), 32'd0);
    wait_ready(0, "a_px1");
    check("a_x1_word", dat[0], {8'd255, 12'd0, 12'd1});

    // start_render mid-calculation is ignored.
    pulse_send(0);
    tick(4);
    pulse_start(0);
    wait_ready(0, "a_px2");
    check("a_x2_word", dat[0], {8'd255, 12'd0, 12'd2});

    pulse_send(0);
    wait_ready(0, "a_px3");
    check("a_x3_word", dat[0], {8'd3, 12'd0, 12'd3});
    check("a_pre_frame_ready", 32'(frdy[0]), 32'd0);

    pulse_send(0);
    check("a_frame_ready", 32'(frdy[0]), 32'd1);
    check("a_done_ready", 32'(rdy[0]), 32'd0);
    tick(5);
    check("a_frame_ready_held", 32'(frdy[0]), 32'd1);

    pulse_start(0);
    check("a_restart_frame_ready", 32'(frdy[0]), 32'd0);
    wait_ready(0, "a_restart_px0");
    check("a_restart_word", dat[0], {8'd255, 12'd0, 12'd0});

    // Reset during CALC aborts the frame.
    pulse_send(0);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("a_midrst_ready", 32'(rdy[0]), 32'd0);
    check("a_midrst_frame_ready", 32'(frdy[0]), 32'd0);
    check("a_midrst_data", dat[0], 32'h0);
    tick(300);
    check("a_midrst_stays_idle", 32'(rdy[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
